// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcode and state definitions plus opcode-class helpers
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SL     = 4'd2,
        OP_SR     = 4'd3,
        OP_INVERT = 4'd4,
        OP_MOV    = 4'd5,
        OP_ASSIGN = 4'd6,
        OP_LW     = 4'd7,
        OP_SW     = 4'd8,
        OP_BEQ    = 4'd9,
        OP_BNE    = 4'd10,
        OP_BGE    = 4'd11,
        OP_JMP    = 4'b1100
    } op_mne;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6,
        ST_TRAP   = 3'd7
    } ctrl_state_e;

    // Opcodes above JMP (1101..1111) are unassigned and trap
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_JMP;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGE) || (op == OP_JMP);
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic zero, input logic ge);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BGE:  taken = ge;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_pc_unit.sv
// rtl/multicycle_ctrl_pc_unit.sv - program counter with +1 / +sext(offset) step and load-zero
module pc_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned OFF_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_zero_i,
    input  logic             step_i,
    input  logic             jump_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [PC_W-1:0]  pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] off_ext;

    assign off_ext = {{(PC_W-OFF_W){off_i[OFF_W-1]}}, off_i};

    // Additions wrap naturally at PC_W bits
    always_comb begin
        pc_d = pc_q;
        if (load_zero_i) begin
            pc_d = '0;
        end else if (jump_i) begin
            pc_d = pc_q + off_ext;
        end else if (step_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH..WB sequencer with branch resolve and memory handshake
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned OFF_W    = 5,
    parameter int unsigned PROG_END = 1023,
    parameter int unsigned MEM_TMO  = 15
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [8:0]      Instr,
    input  logic            Zero_flag,
    input  logic            Ge_flag,
    input  logic            Mem_ack,
    output logic [PC_W-1:0] Prog_addr,
    output logic [8:0]      Ir,
    output logic [3:0]      Alu_op,
    output logic            Reg_we,
    output logic            Wb_sel,
    output logic            Mem_req,
    output logic            Mem_we,
    output logic            Done,
    output logic            Err
);

    localparam logic [PC_W-1:0] END_PC   = PC_W'(PROG_END);
    localparam int unsigned     TMO_W    = $clog2(MEM_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    ctrl_state_e      state_q;
    logic [8:0]       ir_q;
    logic [3:0]       alu_op_q;
    logic             reg_we_q;
    logic             wb_sel_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic             done_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_q;

    logic [3:0]       op;
    logic [PC_W-1:0]  pc;
    logic             start_ok;
    logic             pc_step;
    logic             pc_jump;

    assign op = ir_q[8:5];

    always_comb begin
        start_ok = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_TRAP));
        pc_jump  = (state_q == ST_EXEC) && is_branch(op) && branch_taken(op, Zero_flag, Ge_flag);
        pc_step  = (state_q == ST_WB)
                || ((state_q == ST_EXEC) && is_branch(op) && !pc_jump)
                || ((state_q == ST_MEM) && Mem_ack && (op == OP_SW));
    end

    pc_unit #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_unit (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .load_zero_i (start_ok),
        .step_i      (pc_step),
        .jump_i      (pc_jump),
        .off_i       (ir_q[OFF_W-1:0]),
        .pc_o        (pc)
    );

    // Outputs are registered on the transition into the state they belong to
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            alu_op_q  <= '0;
            reg_we_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            alu_op_q  <= '0;
            reg_we_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_TRAP: begin
                    if (Start) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (pc == END_PC) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        ir_q    <= Instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_illegal(op)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_TRAP;
                    end else begin
                        alu_op_q <= op;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_mem(op)) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (op == OP_SW);
                        tmo_q     <= '0;
                        state_q   <= ST_MEM;
                    end else if (is_branch(op)) begin
                        state_q <= ST_FETCH;
                    end else begin
                        reg_we_q <= 1'b1;
                        state_q  <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (Mem_ack) begin
                        if (op == OP_SW) begin
                            state_q <= ST_FETCH;
                        end else begin
                            reg_we_q <= 1'b1;
                            wb_sel_q <= 1'b1;
                            state_q  <= ST_WB;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_TRAP;
                    end else begin
                        tmo_q     <= tmo_q + TMO_W'(1);
                        mem_req_q <= 1'b1;
                        mem_we_q  <= mem_we_q;
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Prog_addr = pc;
    assign Ir        = ir_q;
    assign Alu_op    = alu_op_q;
    assign Reg_we    = reg_we_q;
    assign Wb_sel    = wb_sel_q;
    assign Mem_req   = mem_req_q;
    assign Mem_we    = mem_we_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule
